// File: rtl/vram_if.sv
// Bus bundle between the VRAM arbiter, its three requesters and the single-port RAM.
// A request is held high until the one-cycle ack pulse; read data follows one cycle after the ack with its rvalid.
interface vram_if;
  logic [15:0] dispcnt;

  logic        disp_req;
  logic [15:0] disp_addr;
  logic [15:0] disp_rdata;
  logic        disp_rvalid;

  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_we;
  logic [1:0]  dma_be;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_burst;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        dma_rvalid;

  logic [15:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  dispcnt,
    input  disp_req, disp_addr,
    output disp_rdata, disp_rvalid,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata, dma_burst,
    output dma_ack, dma_rdata, dma_rvalid,
    output mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output dispcnt,
    output disp_req, disp_addr,
    input  disp_rdata, disp_rvalid,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata, dma_burst,
    input  dma_ack, dma_rdata, dma_rvalid,
    input  mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, CPU and DMA share the rest
// round-robin (DMA can lock with dma_burst). Applies GBA VRAM mirroring and byte-write rules.
module vram_arbiter (
  input  logic       clk,
  input  logic       rst,
  vram_if.slave      bus,
  output logic [1:0] o_dbg_tag,
  output logic       o_dbg_rr_last
);

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_DISP = 2'd1,
    PORT_CPU  = 2'd2,
    PORT_DMA  = 2'd3
  } port_e;

  typedef enum logic {
    RR_CPU = 1'b0,
    RR_DMA = 1'b1
  } rr_e;

  port_e       r_tag;
  port_e       w_tag_nxt;
  port_e       w_win;
  rr_e         r_rr_last;
  rr_e         w_rr_nxt;

  logic [15:0] r_disp_rdata;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_dma_rdata;

  logic        w_req_we;
  logic [1:0]  w_req_be;
  logic [15:0] w_req_addr;
  logic [15:0] w_req_wdata;
  logic [15:0] w_map_addr;
  logic [15:0] w_obj_base;
  logic        w_obj_region;
  logic [7:0]  w_byte;

  logic        w_mem_we;
  logic [1:0]  w_mem_be;
  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;

  logic        w_disp_rvalid;
  logic        w_cpu_rvalid;
  logic        w_dma_rvalid;

  // Winner selection; nothing is granted while reset is held.
  always_comb begin
    w_win = PORT_NONE;
    if (!rst) begin
      if (bus.disp_req) begin
        w_win = PORT_DISP;
      end else if (bus.dma_req && bus.dma_burst) begin
        w_win = PORT_DMA;
      end else if (bus.cpu_req && bus.dma_req) begin
        w_win = (r_rr_last == RR_DMA) ? PORT_CPU : PORT_DMA;
      end else if (bus.cpu_req) begin
        w_win = PORT_CPU;
      end else if (bus.dma_req) begin
        w_win = PORT_DMA;
      end
    end
  end

  // Route the winning port's request onto a common set of wires.
  always_comb begin
    w_req_we    = 1'b0;
    w_req_be    = 2'b00;
    w_req_addr  = 16'h0000;
    w_req_wdata = 16'h0000;
    unique case (w_win)
      PORT_DISP: begin
        w_req_be   = 2'b11;
        w_req_addr = bus.disp_addr;
      end
      PORT_CPU: begin
        w_req_we    = bus.cpu_we;
        w_req_be    = bus.cpu_be;
        w_req_addr  = bus.cpu_addr;
        w_req_wdata = bus.cpu_wdata;
      end
      PORT_DMA: begin
        w_req_we    = bus.dma_we;
        w_req_be    = bus.dma_be;
        w_req_addr  = bus.dma_addr;
        w_req_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  // 0xC000-0xFFFF aliases onto 0x8000-0xBFFF (subtracting 0x4000 only flips bit 14).
  assign w_map_addr   = (w_req_addr[15:14] == 2'b11) ? {2'b10, w_req_addr[13:0]} : w_req_addr;
  assign w_obj_base   = (bus.dispcnt[2:0] >= 3'd3) ? 16'hA000 : 16'h8000;
  assign w_obj_region = (w_map_addr >= w_obj_base);
  assign w_byte       = w_req_be[0] ? w_req_wdata[7:0] : w_req_wdata[15:8];

  // Byte writes below the object area are replicated; byte writes into it are swallowed.
  always_comb begin
    w_mem_addr  = 16'h0000;
    w_mem_we    = 1'b0;
    w_mem_be    = 2'b00;
    w_mem_wdata = 16'h0000;
    if (w_win != PORT_NONE) begin
      w_mem_addr = w_map_addr;
      if (!w_req_we) begin
        w_mem_be = 2'b11;
      end else begin
        unique case (w_req_be)
          2'b11: begin
            w_mem_we    = 1'b1;
            w_mem_be    = 2'b11;
            w_mem_wdata = w_req_wdata;
          end
          2'b01, 2'b10: begin
            if (!w_obj_region) begin
              w_mem_we    = 1'b1;
              w_mem_be    = 2'b11;
              w_mem_wdata = {w_byte, w_byte};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state: response tag follows read grants, rr_last follows CPU/DMA grants.
  always_comb begin
    w_tag_nxt = PORT_NONE;
    w_rr_nxt  = r_rr_last;
    if (w_win != PORT_NONE && !w_req_we) begin
      w_tag_nxt = w_win;
    end
    if (w_win == PORT_CPU) begin
      w_rr_nxt = RR_CPU;
    end else if (w_win == PORT_DMA) begin
      w_rr_nxt = RR_DMA;
    end
  end

  assign w_disp_rvalid = !rst && (r_tag == PORT_DISP);
  assign w_cpu_rvalid  = !rst && (r_tag == PORT_CPU);
  assign w_dma_rvalid  = !rst && (r_tag == PORT_DMA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag        <= PORT_NONE;
      r_rr_last    <= RR_DMA;
      r_disp_rdata <= 16'h0000;
      r_cpu_rdata  <= 16'h0000;
      r_dma_rdata  <= 16'h0000;
    end else begin
      r_tag     <= w_tag_nxt;
      r_rr_last <= w_rr_nxt;
      if (w_disp_rvalid) r_disp_rdata <= bus.mem_rdata;
      if (w_cpu_rvalid)  r_cpu_rdata  <= bus.mem_rdata;
      if (w_dma_rvalid)  r_dma_rdata  <= bus.mem_rdata;
    end
  end

  // Read data is forwarded straight from the RAM in the valid cycle, held registers otherwise.
  assign bus.disp_rvalid = w_disp_rvalid;
  assign bus.cpu_rvalid  = w_cpu_rvalid;
  assign bus.dma_rvalid  = w_dma_rvalid;
  assign bus.disp_rdata  = rst ? 16'h0000 : (w_disp_rvalid ? bus.mem_rdata : r_disp_rdata);
  assign bus.cpu_rdata   = rst ? 16'h0000 : (w_cpu_rvalid  ? bus.mem_rdata : r_cpu_rdata);
  assign bus.dma_rdata   = rst ? 16'h0000 : (w_dma_rvalid  ? bus.mem_rdata : r_dma_rdata);

  assign bus.cpu_ack   = (w_win == PORT_CPU);
  assign bus.dma_ack   = (w_win == PORT_DMA);
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_wdata = w_mem_wdata;

  assign o_dbg_tag     = r_tag;
  assign o_dbg_rr_last = r_rr_last;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios, then randomized traffic checked against a
// queue-based reference model with a decoupled negedge monitor.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_ram = 1'b1;
  logic [1:0] dbg_tag;
  logic       dbg_rr_last;
  int         n_cmp = 0;
  int         n_err = 0;

  vram_if bus ();

  vram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_dbg_tag     (dbg_tag),
    .o_dbg_rr_last (dbg_rr_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // RAM model: one-cycle read latency, byte-enabled writes.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_val(16'(i));
      bus.mem_rdata <= 16'h0000;
    end else begin
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) begin
        if (bus.mem_be[0]) ram[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
        if (bus.mem_be[1]) ram[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        ack_cpu;
    logic        ack_dma;
    logic        we;
    logic        chk_addr;
    logic        chk_data;
    logic        rv_disp;
    logic        rv_cpu;
    logic        rv_dma;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_disp_q[$];
  logic [15:0] exp_cpu_q[$];
  logic [15:0] exp_dma_q[$];
  logic [15:0] ref_ram [0:65535];
  logic        sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: expectation queue empty (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        fail_now("cycle_exp");
      end else begin
        e = exp_q.pop_front();
        check("sb_cpu_ack", 32'(bus.cpu_ack), 32'(e.ack_cpu));
        check("sb_dma_ack", 32'(bus.dma_ack), 32'(e.ack_dma));
        check("sb_mem_we", 32'(bus.mem_we), 32'(e.we));
        check("sb_disp_rvalid", 32'(bus.disp_rvalid), 32'(e.rv_disp));
        check("sb_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e.rv_cpu));
        check("sb_dma_rvalid", 32'(bus.dma_rvalid), 32'(e.rv_dma));
        if (e.chk_addr) check("sb_mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.chk_data) begin
          check("sb_mem_be", 32'(bus.mem_be), 32'(e.be));
          check("sb_mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
        end
      end
      if (bus.disp_rvalid) begin
        if (exp_disp_q.size() == 0) fail_now("disp_rdata");
        else check("sb_disp_rdata", 32'(bus.disp_rdata), 32'(exp_disp_q.pop_front()));
      end
      if (bus.cpu_rvalid) begin
        if (exp_cpu_q.size() == 0) fail_now("cpu_rdata");
        else check("sb_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_q.pop_front()));
      end
      if (bus.dma_rvalid) begin
        if (exp_dma_q.size() == 0) fail_now("dma_rdata");
        else check("sb_dma_rdata", 32'(bus.dma_rdata), 32'(exp_dma_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  int m_last_dma;  // 1 when DMA was the last CPU/DMA port served
  int m_prev_rd;   // port that issued a read last cycle: 0 none, 1 disp, 2 cpu, 3 dma

  function automatic logic [15:0] mirror(input logic [15:0] a);
    return (a >= 16'hC000) ? a - 16'h4000 : a;
  endfunction

  task automatic model_cycle(output int win);
    exp_t        e;
    logic        we;
    logic [1:0]  be;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] ma;
    logic [15:0] obj;
    logic [7:0]  b;
    e = '0;
    e.rv_disp = (m_prev_rd == 1);
    e.rv_cpu  = (m_prev_rd == 2);
    e.rv_dma  = (m_prev_rd == 3);
    m_prev_rd = 0;
    if (bus.disp_req) win = 1;
    else if (bus.dma_req && bus.dma_burst) win = 3;
    else if (bus.cpu_req && bus.dma_req) win = (m_last_dma != 0) ? 2 : 3;
    else if (bus.cpu_req) win = 2;
    else if (bus.dma_req) win = 3;
    else win = 0;
    e.ack_cpu = (win == 2);
    e.ack_dma = (win == 3);
    obj = (bus.dispcnt[2:0] >= 3) ? 16'hA000 : 16'h8000;
    if (win == 0) begin
      e.chk_addr = 1'b1;
      e.chk_data = 1'b1;
    end else if (win == 1) begin
      ma = mirror(bus.disp_addr);
      e.chk_addr = 1'b1;
      e.addr = ma;
      exp_disp_q.push_back(ref_ram[ma]);
      m_prev_rd = 1;
    end else begin
      we = (win == 2) ? bus.cpu_we    : bus.dma_we;
      be = (win == 2) ? bus.cpu_be    : bus.dma_be;
      a  = (win == 2) ? bus.cpu_addr  : bus.dma_addr;
      wd = (win == 2) ? bus.cpu_wdata : bus.dma_wdata;
      ma = mirror(a);
      m_last_dma = (win == 3) ? 1 : 0;
      if (!we) begin
        e.chk_addr = 1'b1;
        e.addr = ma;
        if (win == 2) exp_cpu_q.push_back(ref_ram[ma]);
        else exp_dma_q.push_back(ref_ram[ma]);
        m_prev_rd = win;
      end else if (be == 2'b11 || ((be == 2'b01 || be == 2'b10) && ma < obj)) begin
        b = (be == 2'b01) ? wd[7:0] : wd[15:8];
        e.we = 1'b1;
        e.chk_addr = 1'b1;
        e.chk_data = 1'b1;
        e.addr = ma;
        e.be = 2'b11;
        e.wdata = (be == 2'b11) ? wd : {b, b};
        ref_ram[ma] = e.wdata;
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 65535));
      1:       return 16'h9FF0 + 16'($urandom_range(0, 31));
      2:       return 16'hC000 + 16'($urandom_range(0, 255));
      default: return 16'h7FF8 + 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic clear_reqs();
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.dma_req  = 1'b0;
    bus.dma_burst = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    check("rst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   win;
    logic cpu_hold;
    logic dma_hold;
    bus.dispcnt = 16'h0000;
    bus.disp_addr = 16'h0000;
    bus.cpu_we = 1'b0; bus.cpu_be = 2'b00; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
    bus.dma_we = 1'b0; bus.dma_be = 2'b00; bus.dma_addr = 16'h0000; bus.dma_wdata = 16'h0000;
    clear_reqs();
    for (int i = 0; i < 65536; i++) ref_ram[i] = init_val(16'(i));

    // Reset with a request pending: nothing granted, nothing valid.
    bus.cpu_req = 1'b1;
    @(posedge clk); #1;
    init_ram = 1'b0;
    @(negedge clk);
    check("reset_cpu_ack", 32'(bus.cpu_ack), 32'h0);
    check("reset_mem_we", 32'(bus.mem_we), 32'h0);
    check("reset_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("idle_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("idle_mem_be", 32'(bus.mem_be), 32'h0);
    check("idle_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("idle_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    check("reset_rr_last", 32'(dbg_rr_last), 32'h1);

    // Display fetch: same-cycle address, next-cycle data.
    @(posedge clk); #1;
    bus.disp_req = 1'b1;
    bus.disp_addr = 16'h1234;
    @(negedge clk);
    check("disp_mem_addr", 32'(bus.mem_addr), 32'h1234);
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    @(negedge clk);
    check("disp_rvalid", 32'(bus.disp_rvalid), 32'h1);
    check("disp_rdata", 32'(bus.disp_rdata), 32'hBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("disp_rvalid_drop", 32'(bus.disp_rvalid), 32'h0);
    check("disp_rdata_hold", 32'(bus.disp_rdata), 32'hBEEF);

    // Display blocks the CPU for five cycles.
    @(posedge clk); #1;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prio_cpu_blocked", 32'(bus.cpu_ack), 32'h0);
      @(posedge clk); #1;
    end
    bus.disp_req = 1'b0;
    @(negedge clk);
    check("prio_cpu_ack", 32'(bus.cpu_ack), 32'h1);
    check("prio_cpu_addr", 32'(bus.mem_addr), 32'h0100);

    // Round-robin then burst lock.
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_cpu_ack", 32'(bus.cpu_ack), 32'(i % 2 == 0));
      check("rr_dma_ack", 32'(bus.dma_ack), 32'(i % 2 == 1));
      @(posedge clk); #1;
    end
    bus.dma_burst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_dma_ack", 32'(bus.dma_ack), 32'h1);
      check("burst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
      @(posedge clk); #1;
    end
    clear_reqs();

    // Byte-write rules.
    bus.dispcnt = 16'h0003;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_be = 2'b01;
    bus.cpu_addr = 16'h1000; bus.cpu_wdata = 16'h00AB;
    @(negedge clk);
    check("bw_ack", 32'(bus.cpu_ack), 32'h1);
    check("bw_we", 32'(bus.mem_we), 32'h1);
    check("bw_be", 32'(bus.mem_be), 32'h3);
    check("bw_wdata", 32'(bus.mem_wdata), 32'hABAB);
    ref_ram[16'h1000] = 16'hABAB;
    @(posedge clk); #1;
    bus.cpu_addr = 16'hA000;
    @(negedge clk);
    check("bw_obj_ack", 32'(bus.cpu_ack), 32'h1);
    check("bw_obj_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk); #1;
    bus.cpu_addr = 16'h9FFF; bus.cpu_be = 2'b10; bus.cpu_wdata = 16'hCD00;
    @(negedge clk);
    check("bw_below_a000_we", 32'(bus.mem_we), 32'h1);
    check("bw_below_a000_wdata", 32'(bus.mem_wdata), 32'hCDCD);
    ref_ram[16'h9FFF] = 16'hCDCD;
    @(posedge clk); #1;
    bus.dispcnt = 16'h0000; bus.cpu_addr = 16'h9000;
    @(negedge clk);
    check("bw_mode0_drop_we", 32'(bus.mem_we), 32'h0);
    check("bw_mode0_drop_ack", 32'(bus.cpu_ack), 32'h1);
    @(posedge clk); #1;
    bus.cpu_addr = 16'h0500; bus.cpu_be = 2'b00;
    @(negedge clk);
    check("bw_be00_we", 32'(bus.mem_we), 32'h0);
    check("bw_be00_ack", 32'(bus.cpu_ack), 32'h1);
    @(posedge clk); #1;
    bus.cpu_addr = 16'hE000; bus.cpu_be = 2'b11; bus.cpu_wdata = 16'h1357;
    @(negedge clk);
    check("full_mirror_addr", 32'(bus.mem_addr), 32'hA000);
    check("full_wdata", 32'(bus.mem_wdata), 32'h1357);
    ref_ram[16'hA000] = 16'h1357;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;

    // Mirrored DMA read, then read back an earlier write.
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'hC010;
    @(negedge clk);
    check("mirror_dma_ack", 32'(bus.dma_ack), 32'h1);
    check("mirror_addr", 32'(bus.mem_addr), 32'h8010);
    @(posedge clk); #1;
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1000;
    @(negedge clk);
    check("mirror_dma_rvalid", 32'(bus.dma_rvalid), 32'h1);
    check("mirror_dma_rdata", 32'(bus.dma_rdata), 32'(ref_ram[16'h8010]));
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("readback_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check("readback_cpu_rdata", 32'(bus.cpu_rdata), 32'hABAB);

    // Reset in the cycle after a read grant drops the read.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    @(negedge clk);
    check("midrd_cpu_ack", 32'(bus.cpu_ack), 32'h1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check("midrd_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    check("midrd_mem_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrd_rvalid_after", 32'(bus.cpu_rvalid), 32'h0);
    check("midrd_rr_last", 32'(dbg_rr_last), 32'h1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0020;
    @(negedge clk);
    check("tie_after_reset_cpu", 32'(bus.cpu_ack), 32'h1);
    check("tie_after_reset_dma", 32'(bus.dma_ack), 32'h0);
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    m_last_dma = 0;
    m_prev_rd  = 0;
    cpu_hold   = 1'b0;
    dma_hold   = 1'b0;
    sb_on      = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (c != 0) begin
        @(posedge clk); #1;
      end
      if (!cpu_hold) begin
        bus.cpu_req   = ($urandom_range(0, 99) < 60);
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_be    = 2'($urandom_range(0, 3));
        bus.cpu_addr  = rand_addr();
        bus.cpu_wdata = 16'($urandom);
      end
      if (!dma_hold) begin
        bus.dma_req   = ($urandom_range(0, 99) < 60);
        bus.dma_we    = 1'($urandom_range(0, 1));
        bus.dma_be    = 2'($urandom_range(0, 3));
        bus.dma_addr  = rand_addr();
        bus.dma_wdata = 16'($urandom);
      end
      bus.dma_burst = ($urandom_range(0, 99) < 20);
      bus.disp_req  = ($urandom_range(0, 99) < 25);
      bus.disp_addr = rand_addr();
      if ($urandom_range(0, 9) == 0) bus.dispcnt = {13'h0000, 3'($urandom_range(0, 7))};
      model_cycle(win);
      cpu_hold = bus.cpu_req && (win != 2);
      dma_hold = bus.dma_req && (win != 3);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      clear_reqs();
      model_cycle(win);
    end
    @(negedge clk);
    #1;
    sb_on = 1'b0;
    check("left_cycle_q", 32'(exp_q.size()), 32'h0);
    check("left_disp_q", 32'(exp_disp_q.size()), 32'h0);
    check("left_cpu_q", 32'(exp_cpu_q.size()), 32'h0);
    check("left_dma_q", 32'(exp_dma_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
